// File: rtl/ascon_hash_serdes.sv
// Word-serial message loader and hash unloader around an Ascon hash core.
// Define ASCON_LATENCY_CNT_EN to count cycles from start to core ready.
module ascon_hash_serdes #(
  parameter int W  = 8,
  parameter int Y  = 40,
  parameter int L  = 256,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  data_inxSI,
  input  logic          in_validxSI,
  output logic          in_readyxSO,
  input  logic          abortxSI,
  output logic [Y-1:0]  messagexDO,
  output logic          startxSO,
  input  logic          core_readyxSI,
  input  logic [L-1:0]  core_hashxDI,
  output logic [W-1:0]  data_outxSO,
  output logic          out_validxSO,
  input  logic          out_readyxSI,
  output logic          busyxSO,
  output logic [CW-1:0] latencyxSO
);

  localparam int NIN  = Y / W;
  localparam int NOUT = L / W;
  localparam int IW   = NIN > 1 ? $clog2(NIN) : 1;
  localparam int OW   = NOUT > 1 ? $clog2(NOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    UNLOAD
  } state_t;

  state_t        state;
  logic [IW-1:0] inCnt;
  logic [OW-1:0] outCnt;
  logic [Y-1:0]  msgReg;
  logic [L-1:0]  hashReg;
  logic          startReg;
  logic          outValidReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      inCnt       <= '0;
      outCnt      <= '0;
      msgReg      <= '0;
      hashReg     <= '0;
      startReg    <= 1'b0;
      outValidReg <= 1'b0;
    end else if (abortxSI) begin
      state       <= IDLE;
      inCnt       <= '0;
      outCnt      <= '0;
      startReg    <= 1'b0;
      outValidReg <= 1'b0;
    end else begin
      unique case (state)
        IDLE, LOAD: begin
          if (in_validxSI) begin
            for (int k = 0; k < NIN; k++)
              if (inCnt == IW'(k))
                msgReg[Y-1-k*W -: W] <= data_inxSI;
            if (inCnt == IW'(NIN - 1)) begin
              inCnt    <= '0;
              state    <= START;
              startReg <= 1'b1;
            end else begin
              inCnt <= inCnt + 1'b1;
              state <= LOAD;
            end
          end
        end
        START: begin
          startReg <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (core_readyxSI) begin
            hashReg     <= core_hashxDI;
            outValidReg <= 1'b1;
            state       <= UNLOAD;
          end
        end
        UNLOAD: begin
          if (out_readyxSI) begin
            hashReg <= hashReg << W;
            if (outCnt == OW'(NOUT - 1)) begin
              outCnt      <= '0;
              outValidReg <= 1'b0;
              state       <= IDLE;
            end else begin
              outCnt <= outCnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_readyxSO  = (state == IDLE) || (state == LOAD);
  assign busyxSO      = state != IDLE;
  assign messagexDO   = msgReg;
  assign startxSO     = startReg;
  assign out_validxSO = outValidReg;
  assign data_outxSO  = hashReg[L-1 -: W];

`ifdef ASCON_LATENCY_CNT_EN
  logic [CW-1:0] latCnt;

  // counts every WAIT cycle including the capture cycle, then holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      latCnt <= '0;
    else if (state == START)
      latCnt <= '0;
    else if (state == WAIT && latCnt != '1)
      latCnt <= latCnt + 1'b1;
  end

  assign latencyxSO = latCnt;
`else
  assign latencyxSO = '0;
`endif

endmodule

// File: doc/ascon_hash_serdes.md
ASCON_HASH_SERDES -- requirements
Module: ascon_hash_serdes

Interface
REQ-001 SHALL have parameter W, default 8: words per transfer are W bits wide; legal 1..64; must divide Y and L.
REQ-002 SHALL have parameter Y, default 40: message length in bits.
REQ-003 SHALL have parameter L, default 256: hash length in bits.
REQ-004 SHALL have parameter CW, default 16: latency counter width.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port data_inxSI  in  W  message word, MSB-first order.
REQ-008 SHALL have port in_validxSI  in  1  data_inxSI valid.
REQ-009 SHALL have port in_readyxSO  out  1  word accepted when high together with in_validxSI.
REQ-010 SHALL have port abortxSI  in  1  synchronous abort to IDLE.
REQ-011 SHALL have port messagexDO  out  Y  assembled message to the hash core.
REQ-012 SHALL have port startxSO  out  1  one-cycle start pulse to the core.
REQ-013 SHALL have port core_readyxSI  in  1  core hash-complete flag.
REQ-014 SHALL have port core_hashxDI  in  L  core hash result.
REQ-015 SHALL have port data_outxSO  out  W  hash word, MSB-first order.
REQ-016 SHALL have port out_validxSO  out  1  data_outxSO valid.
REQ-017 SHALL have port out_readyxSI  in  1  consumer accepts word when high with out_validxSO.
REQ-018 SHALL have port busyxSO  out  1  high in every state except IDLE.
REQ-019 SHALL have port latencyxSO  out  CW  cycles from start pulse to core ready.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, START, WAIT, UNLOAD.
REQ-021 SHALL drive in_readyxSO high in IDLE and LOAD only.
REQ-022 SHALL, on each accepted word k (k=0 first), write it to messagexDO[Y-1-k*W -: W]; IDLE->LOAD on the first accept.
REQ-023 SHALL count accepted words; after Y/W words move to START; counter wraps to 0.
REQ-024 SHALL assert startxSO for exactly one cycle, in START, then move to WAIT.
REQ-025 SHALL sample core_readyxSI in WAIT only; ready high in any other state is ignored.
REQ-026 SHALL, on core_readyxSI high in WAIT, capture core_hashxDI into an L-bit shift register and enter UNLOAD next cycle.
REQ-027 SHALL, in UNLOAD, hold out_validxSO high and present hash bits [L-1 -: W]; on each out_readyxSI high, shift left by W bits.
REQ-028 SHALL hold data_outxSO stable while out_validxSO=1 and out_readyxSI=0.
REQ-029 SHALL return to IDLE after L/W words are accepted, dropping out_validxSO in the same cycle.
REQ-030 SHALL hold messagexDO stable from START until the next first accepted word.
REQ-031 SHALL, on abortxSI high in any state, go to IDLE next cycle, clear word counters and force startxSO=0 and out_validxSO=0; messagexDO is retained.
REQ-032 SHALL give abortxSI priority over simultaneous in/out handshakes and core_readyxSI.

Reset
REQ-033 SHALL, while rst=0, force state IDLE, counters 0, messagexDO=0, hash register 0, startxSO=0, out_validxSO=0, data_outxSO=0, busyxSO=0, latencyxSO=0, in_readyxSO=1.
REQ-034 SHALL abandon any operation when reset asserts mid-transfer; no partial word is emitted after release.

Configuration
REQ-035 SHALL use macro ASCON_LATENCY_CNT_EN.
REQ-036 SHALL, with the macro defined, clear latencyxSO in START, increment it once per WAIT cycle (saturating at 2^CW-1), and freeze it from capture until the next START.
REQ-037 SHALL, without the macro, keep port latencyxSO and tie it to 0, with no counter logic.

Verification
REQ-038 SHALL cover: W=8, bytes 61,73,63,6f,6e -> messagexDO=0x6173636f6e, startxSO high exactly one cycle, busyxSO=1.
REQ-039 SHALL cover: core model raises ready 37 cycles after start with hash 0x0123...ef (256 bits) -> 32 words out MSB first, first word 0x01, latencyxSO=37 with macro and 0 without.
REQ-040 SHALL cover: out_readyxSI low for 5 cycles mid-UNLOAD -> data_outxSO and out_validxSO unchanged, no word lost or duplicated.
REQ-041 SHALL cover: abortxSI after 3 of 5 bytes -> IDLE next cycle; a new 5-byte load yields the correct message and a single start pulse.
REQ-042 SHALL cover: rst=0 during UNLOAD word 10 -> all outputs at reset values immediately; core_readyxSI high while in IDLE is ignored.
REQ-043 SHALL cover: W=1, Y=40 -> 40 single-bit accepts build 0x6173636f6e; 256 single-bit outputs match the hash.
